cpu_com_host: RTL and testbench

//  Host-side initiator of the CPU command link. Sends 32-bit command words over 8N1 UART
//  (4 bytes, LSB first) and parses the target's 32-bit replies: READY (3) or a PC word.

---
 rtl/cpu_com_pkg.sv | 25 ++
 rtl/cpu_com_host_if.sv | 35 +++
 rtl/cpu_com_host_uart_byte.sv | 126 ++++++++++++
 rtl/cpu_com_host.sv | 230 +++++++++++++++++++++++
 tb/tb_cpu_com_host.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_com_pkg.sv
// cpu_com_pkg: shared definitions of the CPU command link.
//   Command / response words exchanged between host and target, and the
//   host FSM state encoding (also shown on the debug LEDs).
//   Used by the host and by the target-side controller.
package cpu_com_pkg;

    localparam logic [31:0] CMD_RESET   = 32'd1;
    localparam logic [31:0] CMD_SEND_PC = 32'd2;
    localparam logic [31:0] RSP_READY   = 32'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_CMD = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_WAIT_PC  = 3'd3,
        ST_WAIT_RUN = 3'd4,
        ST_ERROR    = 3'd5
    } host_state_t;

    // States in which reply bytes are accepted and assembled into words.
    function automatic logic is_wait(host_state_t s);
        return (s == ST_WAIT_RDY) || (s == ST_WAIT_PC) || (s == ST_WAIT_RUN);
    endfunction

endpackage

// File: rtl/cpu_com_host_if.sv
// cpu_com_host_if: control/status and serial signals of the host link.
//   master : used by cpu_com_host (initiator of the link)
//            in  start_reset, start_step, rx
//            out tx, busy, target_ready, pc_out, pc_valid, run_done,
//                err_proto, err_timeout, state
//   slave  : used by whatever drives the host (buttons, loader FSM, bench)
interface cpu_com_host_if;
    import cpu_com_pkg::*;

    logic        start_reset;
    logic        start_step;
    logic        rx;
    logic        tx;
    logic        busy;
    logic        target_ready;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        run_done;
    logic        err_proto;
    logic        err_timeout;
    host_state_t state;

    modport master (
        input  start_reset, start_step, rx,
        output tx, busy, target_ready, pc_out, pc_valid, run_done,
               err_proto, err_timeout, state
    );

    modport slave (
        output start_reset, start_step, rx,
        input  tx, busy, target_ready, pc_out, pc_valid, run_done,
               err_proto, err_timeout, state
    );

endinterface

// File: rtl/cpu_com_host_uart_byte.sv
// host_uart_byte: 8N1 byte transmitter and receiver.
//   clk, reset   system clock, synchronous active-low reset
//   tx_start     load tx_data; accepted when idle or in the last cycle of a
//                stop bit (tx_done), so bytes can go back to back
//   tx_data      byte to send, LSB first
//   tx_done      high in the final cycle of the stop bit
//   tx           serial out, idle high, registered
//   rx           raw serial in (asynchronous)
//   rx_valid     one-cycle pulse: rx_data holds a byte with a good stop bit
//   rx_ferr      one-cycle pulse: stop bit sampled low
//   rx_data      received byte
module host_uart_byte #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx,
    input  logic       rx,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic [7:0] rx_data
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    // ---------------- transmitter ----------------
    logic          tx_busy;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_idx;   // 0 start, 1..8 data, 9 stop
    logic [9:0]    tx_sh;

    assign tx_done = tx_busy && (tx_cnt == BIT_END) && (tx_idx == 4'd9);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_idx  <= '0;
            tx_sh   <= '1;
            tx      <= 1'b1;
        end else if (tx_start && (!tx_busy || tx_done)) begin
            tx_busy <= 1'b1;
            tx_cnt  <= '0;
            tx_idx  <= '0;
            tx_sh   <= {1'b1, tx_data, 1'b0};
            tx      <= 1'b0;
        end else if (tx_busy) begin
            if (tx_cnt == BIT_END) begin
                tx_cnt <= '0;
                if (tx_idx == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx      <= 1'b1;
                end else begin
                    tx_idx <= tx_idx + 4'd1;
                    tx_sh  <= {1'b1, tx_sh[9:1]};
                    tx     <= tx_sh[1];
                end
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

    // ---------------- receiver ----------------
    logic          rx_s1, rx_s2, rx_s3;   // s1/s2 synchroniser, s3 for edge detect
    logic          rx_busy;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_idx;
    logic          rx_sample;

    // Start bit is sampled at its middle; every later bit one period after that.
    assign rx_sample = rx_busy && (rx_cnt == ((rx_idx == 4'd0) ? HALF_END : BIT_END));

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_busy  <= 1'b0;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (!rx_busy) begin
                if (rx_s3 && !rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= '0;
                    rx_idx  <= '0;
                end
            end else if (rx_sample) begin
                rx_cnt <= '0;
                case (rx_idx)
                    4'd0: begin
                        // line back high at mid start bit: a glitch, not a byte
                        if (rx_s2) rx_busy <= 1'b0;
                        else       rx_idx  <= 4'd1;
                    end
                    4'd9: begin
                        rx_busy <= 1'b0;
                        if (rx_s2) rx_valid <= 1'b1;
                        else       rx_ferr  <= 1'b1;
                    end
                    default: begin
                        rx_data <= {rx_s2, rx_data[7:1]};
                        rx_idx  <= rx_idx + 4'd1;
                    end
                endcase
            end else begin
                rx_cnt <= rx_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_com_host.sv
// cpu_com_host: host-side initiator of the CPU command link.
//   Sends 32-bit commands as 4 UART bytes (LSB first) and parses the
//   target's 32-bit replies (READY or a PC word).
//   clk    system clock
//   reset  synchronous active-low reset
//   bus    cpu_com_host_if.master: start_reset/start_step requests, rx/tx
//          serial, busy, target_ready, pc_out/pc_valid, run_done,
//          err_proto, err_timeout, state
//   Optional feature macro CPU_COM_TIMEOUT_EN: reply timeout of
//   TIMEOUT_CYCLES in WAIT_RDY / WAIT_PC. Undefined: waits are unbounded and
//   err_timeout stays 0.
module cpu_com_host
    import cpu_com_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 16,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic           clk,
    input  logic           reset,
    cpu_com_host_if.master bus
);

    host_state_t state_q, state_nx, follow_q, follow_nx;

    // FSM action strobes
    logic        load_cmd;
    logic [31:0] cmd_nx;
    logic        set_ready, clr_ready, pc_load, run_pulse;
    logic        set_proto, set_tmo, clr_err;
    logic        tmo_hit;

    // status registers
    logic        ready_q, pc_valid_q, run_done_q, err_proto_q, err_tmo_q;
    logic [31:0] pc_q;

    // command transmit
    logic [31:0] cmd_q;
    logic [1:0]  tx_bidx, tx_sel;
    logic        tx_kick;     // first byte of a freshly loaded command
    logic        tx_start, tx_done;
    logic [7:0]  tx_data;

    // reply receive
    logic        rx_valid, rx_ferr;
    logic [7:0]  rx_data;
    logic [1:0]  rx_bidx;
    logic [23:0] word_lo;
    logic [31:0] word_q;
    logic        word_vld;
    logic        in_wait;

    assign in_wait = is_wait(state_q);

    // On tx_done the next byte must be presented in the same cycle.
    assign tx_sel   = tx_done ? tx_bidx + 2'd1 : tx_bidx;
    assign tx_data  = cmd_q[{tx_sel, 3'b000} +: 8];
    assign tx_start = (state_q == ST_SEND_CMD) && (tx_kick || (tx_done && tx_bidx != 2'd3));

    host_uart_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .tx       (bus.tx),
        .rx       (bus.rx),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .rx_data  (rx_data)
    );

    // Word assembly. Bytes outside WAIT_* are dropped; word_vld is the
    // registered word-complete flag, so decisions land one cycle after the
    // last stop-bit sample.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_bidx  <= '0;
            word_lo  <= '0;
            word_q   <= '0;
            word_vld <= 1'b0;
        end else begin
            word_vld <= in_wait && rx_valid && (rx_bidx == 2'd3);
            if ((state_nx != state_q) && is_wait(state_nx)) begin
                rx_bidx <= '0;
            end else if (in_wait && rx_valid) begin
                rx_bidx <= rx_bidx + 2'd1;
                if (rx_bidx == 2'd3) word_q <= {rx_data, word_lo};
                else                 word_lo[{rx_bidx, 3'b000} +: 8] <= rx_data;
            end
        end
    end

`ifdef CPU_COM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_arm;

    assign tmo_arm = (state_q == ST_WAIT_RDY) || (state_q == ST_WAIT_PC);
    // cnt is 0 in the first cycle of a state, so the hit at TIMEOUT_CYCLES-1
    // moves to ERROR exactly TIMEOUT_CYCLES edges after entry.
    assign tmo_hit = tmo_arm && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset)                                  tmo_cnt <= '0;
        else if ((state_nx != state_q) || rx_valid)  tmo_cnt <= '0;
        else if (tmo_arm)                            tmo_cnt <= tmo_cnt + TW'(1);
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_nx;
    end

    always_comb begin
        state_nx  = state_q;
        follow_nx = follow_q;
        load_cmd  = 1'b0;
        cmd_nx    = CMD_RESET;
        set_ready = 1'b0;
        clr_ready = 1'b0;
        pc_load   = 1'b0;
        run_pulse = 1'b0;
        set_proto = 1'b0;
        set_tmo   = 1'b0;
        clr_err   = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERROR: begin
                // start_reset has priority; from ERROR it is the only exit
                if (bus.start_reset) begin
                    load_cmd  = 1'b1;
                    cmd_nx    = CMD_RESET;
                    follow_nx = ST_WAIT_RDY;
                    clr_ready = 1'b1;
                    clr_err   = (state_q == ST_ERROR);
                    state_nx  = ST_SEND_CMD;
                end else if (bus.start_step && ready_q && state_q == ST_IDLE) begin
                    load_cmd  = 1'b1;
                    cmd_nx    = CMD_SEND_PC;
                    follow_nx = ST_WAIT_PC;
                    state_nx  = ST_SEND_CMD;
                end
            end
            ST_SEND_CMD: begin
                if (tx_done && tx_bidx == 2'd3) state_nx = follow_q;
            end
            ST_WAIT_RDY, ST_WAIT_RUN: begin
                if (rx_ferr) begin
                    set_proto = 1'b1;
                    state_nx  = ST_ERROR;
                end else if (word_vld) begin
                    if (word_q == RSP_READY) begin
                        set_ready = 1'b1;
                        run_pulse = (state_q == ST_WAIT_RUN);
                        state_nx  = ST_IDLE;
                    end else begin
                        set_proto = 1'b1;
                        state_nx  = ST_ERROR;
                    end
                end else if (tmo_hit) begin
                    set_tmo  = 1'b1;
                    state_nx = ST_ERROR;
                end
            end
            ST_WAIT_PC: begin
                if (rx_ferr) begin
                    set_proto = 1'b1;
                    state_nx  = ST_ERROR;
                end else if (word_vld) begin
                    pc_load   = 1'b1;
                    clr_ready = 1'b1;
                    state_nx  = ST_WAIT_RUN;
                end else if (tmo_hit) begin
                    set_tmo  = 1'b1;
                    state_nx = ST_ERROR;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ready_q     <= 1'b0;
            pc_q        <= '0;
            pc_valid_q  <= 1'b0;
            run_done_q  <= 1'b0;
            err_proto_q <= 1'b0;
            err_tmo_q   <= 1'b0;
            cmd_q       <= '0;
            tx_bidx     <= '0;
            tx_kick     <= 1'b0;
            follow_q    <= ST_IDLE;
        end else begin
            pc_valid_q <= pc_load;
            run_done_q <= run_pulse;
            tx_kick    <= load_cmd;
            if (pc_load) pc_q <= word_q;
            if (set_ready)      ready_q <= 1'b1;
            else if (clr_ready) ready_q <= 1'b0;
            if (clr_err) begin
                err_proto_q <= 1'b0;
                err_tmo_q   <= 1'b0;
            end
            if (set_proto) err_proto_q <= 1'b1;
            if (set_tmo)   err_tmo_q   <= 1'b1;
            if (load_cmd) begin
                cmd_q    <= cmd_nx;
                tx_bidx  <= '0;
                follow_q <= follow_nx;
            end else if (tx_done) begin
                tx_bidx <= tx_bidx + 2'd1;
            end
        end
    end

    assign bus.busy         = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    assign bus.target_ready = ready_q;
    assign bus.pc_out       = pc_q;
    assign bus.pc_valid     = pc_valid_q;
    assign bus.run_done     = run_done_q;
    assign bus.err_proto    = err_proto_q;
    assign bus.err_timeout  = err_tmo_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_cpu_com_host.sv
// tb_cpu_com_host: self-checking bench for cpu_com_host with a UART model of
// the target. Expected TX bytes are queued when a command is requested and
// popped as the bytes are decoded from tx.
module tb_cpu_com_host;
    import cpu_com_pkg::*;

    localparam int CPB = 16;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cpu_com_host_if bus();

    cpu_com_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_q[$];

    int cyc = 0;
    int pcv_cnt = 0;
    int run_cnt = 0;
    int txlow_cnt = 0;
    logic [31:0] pc_at_v = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.pc_valid === 1'b1) begin
            pcv_cnt <= pcv_cnt + 1;
            pc_at_v <= bus.pc_out;
        end
        if (bus.run_done === 1'b1) run_cnt <= run_cnt + 1;
        if (bus.tx === 1'b0) txlow_cnt <= txlow_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input string tag, input host_state_t s, input int max);
        int i = 0;
        while (bus.state !== s && i < max) begin
            @(negedge clk);
            i++;
        end
        chk(tag, bus.state, s);
    endtask

    task automatic pulse_start(input bit r, input bit s);
        @(negedge clk);
        bus.start_reset = r;
        bus.start_step  = s;
        @(negedge clk);
        bus.start_reset = 1'b0;
        bus.start_step  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        cycles(3);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic expect_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
    endtask

    // Decode one byte from tx, sampling each bit in its middle.
    task automatic recv_byte(output logic [7:0] b);
        int i = 0;
        b = '0;
        while (bus.tx !== 1'b0 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk("tx_start_bit", bus.tx, 1'b0);
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            repeat (CPB) @(negedge clk);
            b[k] = bus.tx;
        end
        repeat (CPB) @(negedge clk);
        chk("tx_stop_bit", bus.tx, 1'b1);
    endtask

    task automatic recv_word(input string tag);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            recv_byte(b);
            if (exp_q.size() > 0) chk(tag, b, exp_q.pop_front());
            else                  chk({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stopb);
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            bus.rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = stopb;
        repeat (CPB) @(negedge clk);
        bus.rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, r0, t0;
        bus.start_reset = 1'b0;
        bus.start_step  = 1'b0;
        bus.rx          = 1'b1;
        cycles(3);

        // reset state
        chk("rst_tx", bus.tx, 1'b1);
        chk("rst_state", bus.state, ST_IDLE);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ready", bus.target_ready, 1'b0);
        chk("rst_pc", bus.pc_out, 32'h0);
        chk("rst_pcv", bus.pc_valid, 1'b0);
        chk("rst_run", bus.run_done, 1'b0);
        chk("rst_errp", bus.err_proto, 1'b0);
        chk("rst_errt", bus.err_timeout, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // 1: start_reset together with start_step -> reset command wins
        expect_word(CMD_RESET);
        pulse_start(1'b1, 1'b1);
        chk("t1_busy", bus.busy, 1'b1);
        recv_word("t1_tx_byte");
        wait_state("t1_wait_rdy", ST_WAIT_RDY, 100);
        send_word(RSP_READY);
        wait_state("t1_idle", ST_IDLE, 200);
        chk("t1_ready", bus.target_ready, 1'b1);
        chk("t1_busy_low", bus.busy, 1'b0);

        // 2: step -> PC word -> READY
        p0 = pcv_cnt;
        r0 = run_cnt;
        expect_word(CMD_SEND_PC);
        pulse_start(1'b0, 1'b1);
        recv_word("t2_tx_byte");
        wait_state("t2_wait_pc", ST_WAIT_PC, 100);
        send_word(32'h0000_0040);
        wait_state("t2_wait_run", ST_WAIT_RUN, 200);
        cycles(2);
        chk("t2_pc_out", bus.pc_out, 32'h40);
        chk("t2_pc_at_valid", pc_at_v, 32'h40);
        chk("t2_pcv_pulses", 32'(pcv_cnt - p0), 32'd1);
        chk("t2_ready_clr", bus.target_ready, 1'b0);
        send_word(RSP_READY);
        wait_state("t2_idle", ST_IDLE, 200);
        cycles(2);
        chk("t2_run_pulses", 32'(run_cnt - r0), 32'd1);
        chk("t2_ready", bus.target_ready, 1'b1);
        chk("t2_pc_hold", bus.pc_out, 32'h40);

        // 3: step before any READY is ignored
        apply_reset();
        t0 = txlow_cnt;
        pulse_start(1'b0, 1'b1);
        cycles(100 * CPB);
        chk("t3_tx_idle", 32'(txlow_cnt - t0), 32'd0);
        chk("t3_state", bus.state, ST_IDLE);

        // 4: wrong reply in WAIT_RDY -> ERROR; step ignored; reset recovers
        expect_word(CMD_RESET);
        pulse_start(1'b1, 1'b0);
        recv_word("t4_tx_byte");
        wait_state("t4_wait_rdy", ST_WAIT_RDY, 100);
        send_word(32'h0000_0005);
        wait_state("t4_error", ST_ERROR, 200);
        chk("t4_err_proto", bus.err_proto, 1'b1);
        chk("t4_busy", bus.busy, 1'b0);
        t0 = txlow_cnt;
        pulse_start(1'b0, 1'b1);
        cycles(50);
        chk("t4_step_ignored", bus.state, ST_ERROR);
        chk("t4_tx_quiet", 32'(txlow_cnt - t0), 32'd0);
        expect_word(CMD_RESET);
        pulse_start(1'b1, 1'b0);
        chk("t4_err_cleared", bus.err_proto, 1'b0);
        chk("t4_resend", bus.state, ST_SEND_CMD);
        recv_word("t4_resend_byte");
        wait_state("t4_wait_rdy2", ST_WAIT_RDY, 100);
        send_word(RSP_READY);
        wait_state("t4_idle", ST_IDLE, 200);
        chk("t4_ready", bus.target_ready, 1'b1);

        // 5a: framing error on a reply byte
        expect_word(CMD_RESET);
        pulse_start(1'b1, 1'b0);
        recv_word("t5_tx_byte");
        wait_state("t5_wait_rdy", ST_WAIT_RDY, 100);
        send_byte(8'h03, 1'b0);
        wait_state("t5_ferr_error", ST_ERROR, 100);
        chk("t5_err_proto", bus.err_proto, 1'b1);

        // 5b: reset in the middle of the second TX byte
        apply_reset();
        pulse_start(1'b1, 1'b0);
        cycles(CPB * 10 + CPB * 5);
        chk("t5_mid_tx_low", bus.tx, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_rst_tx", bus.tx, 1'b1);
        chk("t5_rst_state", bus.state, ST_IDLE);
        reset = 1'b1;
        cycles(2);

        // 6: no reply in WAIT_RDY
        expect_word(CMD_RESET);
        pulse_start(1'b1, 1'b0);
        recv_word("t6_tx_byte");
        wait_state("t6_wait_rdy", ST_WAIT_RDY, 100);
        t0 = cyc;
`ifdef CPU_COM_TIMEOUT_EN
        begin
            int i = 0;
            while (bus.err_timeout !== 1'b1 && i < 2 * TMO) begin
                @(negedge clk);
                i++;
            end
        end
        chk("t6_err_timeout", bus.err_timeout, 1'b1);
        chk("t6_tmo_cycles", 32'(cyc - t0), 32'(TMO));
        chk("t6_tmo_state", bus.state, ST_ERROR);
`else
        cycles(5000);
        chk("t6_still_waiting", bus.state, ST_WAIT_RDY);
        chk("t6_no_timeout", bus.err_timeout, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
